spi_master_sched: RTL and testbench
===================================

# spi_master_sched

Two-requester SPI master that shares one SPI bus (ss/sck/mosi/miso) between two on-chip clients and sequences each byte transfer. It pairs with `spi_slave` as its link partner. The bus protocol is mode 0, MSB first, one byte per transaction, with sck derived from the system clock. A round-robin arbiter picks the next client. The sequencer generates chip-select, clock and data, and returns the received byte with a completion pulse.

## Interface
- `CLK_DIV`, default 4: system-clock cycles per sck half-period. Legal range is 2..255.
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 2: per-client transfer request. Held high until the matching `done` bit pulses.
- `wdata0` in 8: byte to send for client 0.
- `wdata1` in 8: byte to send for client 1.
- `gnt` out 2: one-hot grant. High from acceptance until `done`.
- `done` out 2: one-cycle completion pulse for the granted client.
- `rdata` out 8: byte received on miso. Valid when `done` pulses; held until the next `done`.
- `busy` out 1: high from grant until the end of the GAP state.
- `ss` out 1: active-low chip select.
- `sck` out 1: SPI clock, idle low.
- `mosi` out 1: serial data out.
- `miso` in 1: serial data in.

## Operation
- Reset values:
  - `ss`=1, `sck`=0, `mosi`=1.
  - `gnt`=0, `done`=0, `rdata`=8'h00, `busy`=0.
  - State = IDLE. Round-robin pointer = last-served 1, so client 0 wins first.
- States run IDLE → SETUP → HIGH ↔ LOW (8 bit periods) → GAP → IDLE. Every state except IDLE lasts exactly `CLK_DIV` cycles, counted by a divider counter.
- IDLE: if any `req` bit is high, register the winner.
  - Only one request: grant it.
  - Both requests: grant the client not served last.
  - Capture that client's `wdata` into the shift register. Set `gnt` and `busy`. Go to SETUP.
- SETUP: `ss`=0, `mosi`=bit 7, `sck`=0.
- HIGH: `sck`=1. `miso` is shifted in (`rx <= {rx[6:0], miso}`) on the clk edge that sets `sck` high.
- LOW: `sck`=0. `mosi` advances to the next bit on the edge that sets `sck` low.
  - After the 8th LOW, go to GAP.
- GAP:
  - Outputs: `ss`=1, `mosi`=1.
  - On entry: `rdata` ← rx, `done[g]` pulses for one cycle, `gnt` clears, pointer ← g.
  - `busy` drops on the return to IDLE.
- If a client drops `req` mid-transfer, the transfer still completes and `done` still pulses.
- `req` changes while not in IDLE are ignored.
- Asynchronous reset mid-transfer forces the reset values at once. `ss` goes high, there is no `done`, and the partial byte is discarded.

## Timing
- Acceptance: grant is registered on the edge after `req` is seen in IDLE. `gnt` and `ss`=0 appear together.
- `ss` stays low for 17×`CLK_DIV` cycles (68 at the default).
- `done` pulses 17×`CLK_DIV` cycles after `gnt` rises.
- Back-to-back transfers: `ss` is high for at least `CLK_DIV`+1 cycles (the GAP plus one IDLE cycle).
- Throughput: one byte per 18×`CLK_DIV`+1 cycles.
- sck period is 2×`CLK_DIV`. The first rising edge comes `CLK_DIV` cycles after `ss` falls.
- `mosi` is stable for `CLK_DIV` cycles on both sides of each sck rising edge.

## Configuration
- `SPI_SCHED_DBG_EN` defined: adds output port `dbg` [7:0] = {`gnt`[1:0], state[2:0], bitcnt[2:0]}, registered.
- Not defined: the port and its logic are absent. Function and timing are otherwise identical.

## Structure
- Package `spi_pkg` holds:
  - the state enum (IDLE, SETUP, HIGH, LOW, GAP);
  - `SPI_BITS`=8;
  - the divider counter width constant.
- Sub-module `spi_rr_arb`: 2-way round-robin arbiter. Inputs are `req` and the last-served pointer; output is the one-hot winner. It is combinational, and the sequencer registers the winner.
- The sequencer owns the divider, the bit counter, the shift registers and the bus outputs.

## Test plan
- Client 0 request, `wdata0`=8'hA5, slave returns 8'h3C:
  - mosi sees 1,0,1,0,0,1,0,1 on the sck rising edges;
  - `rdata`=8'h3C with `done`=2'b01;
  - `ss` low for exactly 68 cycles at `CLK_DIV`=4.
- Both requests held from reset, `wdata0`=8'h11, `wdata1`=8'h22:
  - grants go 01, 10, 01, 10;
  - mosi bytes go 11, 22, 11, 22;
  - `ss` is high for at least 5 cycles between transfers.
- Client 1 drops `req` 10 cycles after grant:
  - the transfer still completes;
  - `done`=2'b10 pulses once;
  - there is no re-grant to client 1 unless it requests again.
- `rst_n` asserted during bit 4:
  - `ss`=1, `sck`=0, `mosi`=1 immediately;
  - no `done`;
  - the next request starts a clean SETUP.
- `CLK_DIV`=2: sck period is 4 cycles and a single transfer is exact.
- With `SPI_SCHED_DBG_EN`: `dbg`[2:0] counts 0..7 through the byte and `dbg`[7:6] mirrors `gnt`.

Source files
------------

// File: rtl/spi_master_sched_pkg.sv
// spi_pkg: shared definitions for the spi_master_sched block.
// Holds the sequencer state encoding, the byte length and the width of the
// sck divider counter. Imported by the arbiter and by the top.
// Ports: none (package only).

package spi_pkg;

  // Bits per SPI transaction.
  localparam int SPI_BITS = 8;

  // Divider counter width; covers CLK_DIV values up to 255.
  localparam int DIV_W = 8;

  // Sequencer states. The encoding is 3 bits so it can be exposed on dbg.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_HIGH  = 3'd2,
    ST_LOW   = 3'd3,
    ST_GAP   = 3'd4
  } state_e;

endpackage

// File: rtl/spi_master_sched_if.sv
// spi_master_sched_if: client handshake plus SPI pins of spi_master_sched.
//
// Client handshake: a client raises req[i] with its byte on wdata<i> and
// holds both until done[i] pulses. gnt[i] is high from acceptance until
// done; rdata is valid on the done pulse and held until the next done.
// busy covers the whole transfer including the trailing gap.
//
// Signals:
//   req[1:0], wdata0[7:0], wdata1[7:0]  client -> master
//   gnt[1:0], done[1:0], rdata[7:0], busy  master -> client
//   ss, sck, mosi                        master -> SPI slave
//   miso                                 SPI slave -> master
// Modports: master (the spi_master_sched side), slave (clients + SPI slave).

interface spi_master_sched_if;
  import spi_pkg::*;

  logic [1:0] req;
  logic [7:0] wdata0;
  logic [7:0] wdata1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic [7:0] rdata;
  logic       busy;
  logic       ss;
  logic       sck;
  logic       mosi;
  logic       miso;

  modport master (
    input  req, wdata0, wdata1, miso,
    output gnt, done, rdata, busy, ss, sck, mosi
  );

  modport slave (
    output req, wdata0, wdata1, miso,
    input  gnt, done, rdata, busy, ss, sck, mosi
  );

endinterface

// File: rtl/spi_master_sched_rr_arb.sv
// spi_rr_arb: combinational 2-way round-robin arbiter.
// Ports:
//   req[1:0]  in  : pending requests
//   last      in  : index of the client served last (0 or 1)
//   win[1:0]  out : one-hot winner, 2'b00 when nothing is requested
// On a tie the client that was not served last wins.

module spi_rr_arb
  import spi_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] win
);

  always_comb begin
    win = 2'b00;
    case (req)
      2'b01:   win = 2'b01;
      2'b10:   win = 2'b10;
      2'b11:   win = last ? 2'b01 : 2'b10;
      default: win = 2'b00;
    endcase
  end

endmodule

// File: rtl/spi_master_sched.sv
// spi_master_sched: two-client SPI master (mode 0, MSB first, one byte per
// transaction) with round-robin arbitration between the clients.
//
// Ports:
//   clk     in  : system clock, rising edge
//   rst_n   in  : asynchronous active-low reset
//   bus         : spi_master_sched_if.master (client handshake + SPI pins)
//   dbg     out : {gnt, state, bitcnt}, registered; only present when the
//                 macro SPI_SCHED_DBG_EN is defined
// Parameter:
//   CLK_DIV : system clocks per sck half-period (2..255)
//
// Sequence: IDLE -> SETUP -> (HIGH -> LOW) x8 -> GAP -> IDLE. Every state
// except IDLE lasts CLK_DIV cycles. All bus outputs are registered and change
// on the edge that enters the state they belong to.

module spi_master_sched
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  spi_master_sched_if.master bus
`ifdef SPI_SCHED_DBG_EN
  ,
  output logic [7:0]         dbg
`endif
);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q;
  logic [2:0]       bit_q;
  logic [7:0]       tx_q;
  logic [7:0]       rx_q;
  logic [1:0]       gnt_q;
  logic [1:0]       done_q;
  logic [7:0]       rdata_q;
  logic             busy_q;
  logic             ss_q;
  logic             sck_q;
  logic             mosi_q;
  logic             last_q;
  logic [1:0]       win;

  logic div_last;
  logic bit_last;
  logic accept;
  logic go_high;
  logic go_low;
  logic go_gap;
  logic go_idle;

  assign div_last = (div_q == DIV_W'(CLK_DIV - 1));
  assign bit_last = (bit_q == 3'(SPI_BITS - 1));

  spi_rr_arb u_arb (
    .req  (bus.req),
    .last (last_q),
    .win  (win)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (|bus.req) state_d = ST_SETUP;
      ST_SETUP: if (div_last) state_d = ST_HIGH;
      ST_HIGH:  if (div_last) state_d = ST_LOW;
      ST_LOW:   if (div_last) state_d = bit_last ? ST_GAP : ST_HIGH;
      ST_GAP:   if (div_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output decode: one strobe per state transition, consumed by the datapath.
  always_comb begin
    accept  = 1'b0;
    go_high = 1'b0;
    go_low  = 1'b0;
    go_gap  = 1'b0;
    go_idle = 1'b0;
    case (state_q)
      ST_IDLE:  accept  = |bus.req;
      ST_SETUP: go_high = div_last;
      ST_HIGH:  go_low  = div_last;
      ST_LOW: begin
        go_high = div_last && !bit_last;
        go_gap  = div_last && bit_last;
      end
      ST_GAP:   go_idle = div_last;
      default: ;
    endcase
  end

  // Divider: held at 0 in IDLE so every timed state starts from a full count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              div_q <= '0;
    else if (state_q == ST_IDLE || div_last) div_q <= '0;
    else                                     div_q <= div_q + 1'b1;
  end

  // Datapath and bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      ss_q    <= 1'b1;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b1;
      last_q  <= 1'b1;
    end else begin
      done_q <= 2'b00;
      if (accept) begin
        gnt_q  <= win;
        busy_q <= 1'b1;
        ss_q   <= 1'b0;
        sck_q  <= 1'b0;
        bit_q  <= '0;
        tx_q   <= win[1] ? bus.wdata1 : bus.wdata0;
        mosi_q <= win[1] ? bus.wdata1[7] : bus.wdata0[7];
      end
      if (go_high) begin
        // miso is sampled on the edge that raises sck.
        sck_q <= 1'b1;
        rx_q  <= {rx_q[6:0], bus.miso};
        if (state_q == ST_LOW) bit_q <= bit_q + 3'd1;
      end
      if (go_low) begin
        // Next bit is presented on the edge that lowers sck; the 1 shifted in
        // only reaches mosi after the last bit, where GAP forces mosi high.
        sck_q  <= 1'b0;
        tx_q   <= {tx_q[6:0], 1'b1};
        mosi_q <= tx_q[6];
      end
      if (go_gap) begin
        ss_q    <= 1'b1;
        mosi_q  <= 1'b1;
        rdata_q <= rx_q;
        done_q  <= gnt_q;
        gnt_q   <= 2'b00;
        last_q  <= gnt_q[1];
      end
      if (go_idle) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;
  assign bus.ss    = ss_q;
  assign bus.sck   = sck_q;
  assign bus.mosi  = mosi_q;

`ifdef SPI_SCHED_DBG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dbg <= '0;
    else        dbg <= {gnt_q, state_q, bit_q};
  end
`endif

endmodule

// File: tb/tb_spi_master_sched.sv
// tb_spi_master_sched: directed bench for spi_master_sched.
// dut runs at CLK_DIV=4 with a mode-0 slave model; dut2 runs at CLK_DIV=2
// with miso looped back to mosi. Expected {done, rdata, mosi byte} entries
// are queued when a request is driven and popped when done pulses.

module tb_spi_master_sched;
  import spi_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  spi_master_sched_if bus ();
  spi_master_sched_if bus2 ();

`ifdef SPI_SCHED_DBG_EN
  logic [7:0] dbg;
  logic [7:0] dbg2;
`endif

  spi_master_sched #(.CLK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef SPI_SCHED_DBG_EN
    ,
    .dbg   (dbg)
`endif
  );

  spi_master_sched #(.CLK_DIV(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
`ifdef SPI_SCHED_DBG_EN
    ,
    .dbg   (dbg2)
`endif
  );

  assign bus2.miso = bus2.mosi;

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [17:0] exp_q[$];
  int n_done0 = 0;
  int n_done1 = 0;
  bit gap_chk = 1'b0;
  logic [7:0] slave_tx = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- SPI slave model (mode 0) ----------------
  logic s_prev_ss = 1'b1;
  logic s_prev_sck = 1'b0;
  int   s_idx = 7;

  initial bus.miso = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      s_idx = 7;
    end else if (s_prev_ss && !bus.ss) begin
      bus.miso = slave_tx[7];
      s_idx = 6;
    end else if (!bus.ss && s_prev_sck && !bus.sck && s_idx >= 0) begin
      bus.miso = slave_tx[s_idx];
      s_idx--;
    end
    s_prev_ss  = bus.ss;
    s_prev_sck = bus.sck;
  end

  // ---------------- monitor / checker for dut ----------------
  logic        m_prev_ss = 1'b1;
  logic        m_prev_sck = 1'b0;
  logic [1:0]  m_prev_done = 2'b00;
  bit          m_in_xfer = 1'b0;
  bit          m_first = 1'b0;
  bit          m_gap_armed = 1'b0;
  int          m_low = 0;
  int          m_high = 0;
  int          m_cyc = 0;
  int          m_hi = 0;
  int          m_bits = 0;
  int          m_ss_len = 0;
  logic [7:0]  m_byte = 8'h00;
  logic [17:0] m_exp;
  bit          m_avail;

  always @(negedge clk) begin
    if (!rst_n) begin
      if (m_in_xfer && exp_q.size() > 0) m_exp = exp_q.pop_front();
      m_in_xfer   = 1'b0;
      m_first     = 1'b0;
      m_gap_armed = 1'b0;
    end else begin
      if (m_prev_ss && !bus.ss) begin
        m_avail = (exp_q.size() > 0);
        check("grant_expected", 32'(m_avail), 32'd1);
        if (m_avail) check("gnt_at_ss_fall", 32'(bus.gnt), 32'(exp_q[0][17:16]));
        check("busy_at_ss_fall", 32'(bus.busy), 32'd1);
        if (gap_chk && m_gap_armed) check("ss_gap", m_high, 5);
        m_gap_armed = 1'b0;
        m_in_xfer = 1'b1;
        m_low = 1; m_cyc = 0; m_first = 1'b1; m_bits = 0; m_byte = 8'h00;
      end else if (!bus.ss) begin
        m_low++;
        m_cyc++;
      end else begin
        m_high++;
      end
      if (!m_prev_ss && bus.ss) begin
        m_ss_len = m_low;
        m_high = 1;
        m_gap_armed = gap_chk;
      end
      if (!bus.ss && !m_prev_sck && bus.sck) begin
        if (m_first) check("first_sck_rise", m_cyc, 4);
        m_first = 1'b0;
        m_byte = {m_byte[6:0], bus.mosi};
        m_bits++;
        m_hi = 1;
      end else if (bus.sck) begin
        m_hi++;
      end
      if (m_prev_sck && !bus.sck) check("sck_high_len", m_hi, 4);
      if (bus.done !== 2'b00) begin
        check("done_width", 32'(m_prev_done), 32'd0);
        if (bus.done == 2'b01) n_done0++;
        else if (bus.done == 2'b10) n_done1++;
        m_avail = (exp_q.size() > 0);
        check("done_expected", 32'(m_avail), 32'd1);
        if (m_avail) begin
          m_exp = exp_q.pop_front();
          check("done_rdata_mosi", 32'({bus.done, bus.rdata, m_byte}), 32'(m_exp));
        end
        check("mosi_bits", m_bits, 8);
        check("ss_low_len", m_ss_len, 68);
        check("gnt_clear_at_done", 32'(bus.gnt), 32'd0);
        check("busy_at_done", 32'(bus.busy), 32'd1);
        m_in_xfer = 1'b0;
      end
    end
    m_prev_ss   = bus.ss;
    m_prev_sck  = bus.sck;
    m_prev_done = bus.done;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done(input int budget);
    int start;
    bit got;
    start = n_done0 + n_done1;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk); #1;
      if (n_done0 + n_done1 != start) got = 1'b1;
    end
    check("wait_done", 32'(got), 32'd1);
  endtask

  task automatic wait_idle(input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk); #1;
      if (bus.busy === 1'b0) got = 1'b1;
    end
    check("wait_idle", 32'(got), 32'd1);
  endtask

  task automatic wait_gnt(input logic [1:0] g, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk); #1;
      if (bus.gnt === g) got = 1'b1;
    end
    check("wait_gnt", 32'(got), 32'd1);
  endtask

  task automatic wait_bits(input int nb, input int budget);
    bit got;
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk); #1;
      if (m_bits >= nb) got = 1'b1;
    end
    check("wait_bits", 32'(got), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  int d0, d1;
  int k, fall_k, last_rise, low2, rise2, first_off, period_bad, done2_cnt;
  logic [1:0] done2_val, prev_gnt2;
  logic [7:0] rd2;
  logic prev_ss2, prev_sck2;
  int dbg_bad, dbg_max;

  initial begin
    bus.req = 2'b00; bus.wdata0 = 8'h00; bus.wdata1 = 8'h00;
    bus2.req = 2'b00; bus2.wdata0 = 8'h00; bus2.wdata1 = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ss", 32'(bus.ss), 32'd1);
    check("rst_sck", 32'(bus.sck), 32'd0);
    check("rst_mosi", 32'(bus.mosi), 32'd1);
    check("rst_gnt", 32'(bus.gnt), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    #1;

    // Single client-0 transfer.
    slave_tx = 8'h3C;
    bus.wdata0 = 8'hA5;
    exp_q.push_back({2'b01, 8'h3C, 8'hA5});
    bus.req = 2'b01;
    wait_done(200);
    bus.req = 2'b00;
    wait_idle(50);
    repeat (20) @(negedge clk);
    #1;
    check("rdata_held", 32'(bus.rdata), 32'h3C);

    // Both clients held from reset: alternate grants.
    rst_n = 1'b0;
    bus.req = 2'b11; bus.wdata0 = 8'h11; bus.wdata1 = 8'h22;
    slave_tx = 8'h5A;
    exp_q.push_back({2'b01, 8'h5A, 8'h11});
    exp_q.push_back({2'b10, 8'h5A, 8'h22});
    exp_q.push_back({2'b01, 8'h5A, 8'h11});
    exp_q.push_back({2'b10, 8'h5A, 8'h22});
    gap_chk = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) wait_done(200);
    bus.req = 2'b00;
    gap_chk = 1'b0;
    wait_idle(50);
    check("rr_done0_count", n_done0, 3);
    check("rr_done1_count", n_done1, 2);

    // Client 1 drops req 10 cycles after grant.
    d1 = n_done1;
    slave_tx = 8'h81;
    bus.wdata1 = 8'hC3;
    exp_q.push_back({2'b10, 8'h81, 8'hC3});
    bus.req = 2'b10;
    wait_gnt(2'b10, 20);
    repeat (10) @(negedge clk);
    #1;
    bus.req = 2'b00;
    wait_done(200);
    repeat (100) @(negedge clk);
    #1;
    check("drop_done1_once", n_done1, d1 + 1);
    check("drop_no_regrant", 32'(bus.gnt), 32'd0);
    check("drop_not_busy", 32'(bus.busy), 32'd0);
    check("drop_ss_high", 32'(bus.ss), 32'd1);

    // Reset during bit 4.
    d0 = n_done0; d1 = n_done1;
    slave_tx = 8'h0F;
    bus.wdata0 = 8'hF0;
    exp_q.push_back({2'b01, 8'h0F, 8'hF0});
    bus.req = 2'b01;
    wait_bits(5, 200);
    rst_n = 1'b0;
    bus.req = 2'b00;
    #1;
    check("abort_ss", 32'(bus.ss), 32'd1);
    check("abort_sck", 32'(bus.sck), 32'd0);
    check("abort_mosi", 32'(bus.mosi), 32'd1);
    check("abort_gnt", 32'(bus.gnt), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (80) @(negedge clk);
    #1;
    check("abort_no_done", n_done0 + n_done1, d0 + d1);
    check("abort_rdata", 32'(bus.rdata), 32'd0);
    check("abort_q_drained", exp_q.size(), 0);
    slave_tx = 8'hE7;
    bus.wdata0 = 8'h3C;
    exp_q.push_back({2'b01, 8'hE7, 8'h3C});
    bus.req = 2'b01;
    wait_done(200);
    bus.req = 2'b00;
    wait_idle(50);

    // CLK_DIV=2 instance, miso looped back to mosi.
    k = 0; fall_k = 0; last_rise = 0; low2 = 0; rise2 = 0; first_off = -1;
    period_bad = 0; done2_cnt = 0; done2_val = 2'b00; rd2 = 8'h00;
    prev_ss2 = bus2.ss; prev_sck2 = bus2.sck; prev_gnt2 = bus2.gnt;
    dbg_bad = 0; dbg_max = 0;
    bus2.wdata0 = 8'h96;
    bus2.req = 2'b01;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      k++;
      if (prev_ss2 && !bus2.ss) fall_k = k;
      if (!bus2.ss) low2++;
      if (!prev_sck2 && bus2.sck) begin
        rise2++;
        if (rise2 == 1) first_off = k - fall_k;
        else if (k - last_rise != 4) period_bad++;
        last_rise = k;
      end
      if (bus2.done !== 2'b00) begin
        done2_cnt++;
        done2_val = bus2.done;
        rd2 = bus2.rdata;
        #1;
        bus2.req = 2'b00;
      end
`ifdef SPI_SCHED_DBG_EN
      if (dbg2[7:6] !== prev_gnt2) dbg_bad++;
      if (bus2.busy && int'(dbg2[2:0]) > dbg_max) dbg_max = int'(dbg2[2:0]);
`endif
      prev_ss2 = bus2.ss; prev_sck2 = bus2.sck; prev_gnt2 = bus2.gnt;
    end
    check("div2_ss_low", low2, 34);
    check("div2_sck_rises", rise2, 8);
    check("div2_first_rise", first_off, 2);
    check("div2_period_bad", period_bad, 0);
    check("div2_done_count", done2_cnt, 1);
    check("div2_done_val", 32'(done2_val), 32'd1);
    check("div2_rdata", 32'(rd2), 32'h96);
`ifdef SPI_SCHED_DBG_EN
    check("dbg_gnt_mirror", dbg_bad, 0);
    check("dbg_bitcnt_max", dbg_max, 7);
`endif

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
